// File: rtl/fim_wrack_scfifo.sv
// Single-clock FIFO: valid/ready handshake on the write side, rdreq pop with
// one-cycle registered rdata/rvalid on the read side.
module fim_wrack_scfifo #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned DEPTH_LOG2            = 5,
  parameter int unsigned ALMOST_FULL_THRESHOLD = 2**(DEPTH_LOG2-1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  empty,
  output logic                  full,
  output logic                  almfull,
  output logic                  underflow
);

  localparam int unsigned         DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AF_THR    = ALMOST_FULL_THRESHOLD[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0]   wptr;
  logic [DEPTH_LOG2:0]   rptr;
  logic                  wr_en;
  logic                  rd_en;

  // Flags derive only from the registered pointers, so wready has no path
  // from wvalid or rdreq.
  always_comb begin
    usedw   = wptr - rptr;
    empty   = (usedw == '0);
    full    = (usedw == DEPTH_CNT);
    almfull = (usedw >= AF_THR);
    wready  = ~full;
    wr_en   = wvalid & wready;
    rd_en   = rdreq & ~empty;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (wr_en) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_en) begin
        rptr  <= rptr + PTR_ONE;
        rdata <= mem[rptr[DEPTH_LOG2-1:0]];
      end
      if (rdreq && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fim_wrack_scfifo.sv
// Directed, table-driven bench for fim_wrack_scfifo at depth 4, almost-full at 2.
module tb_fim_wrack_scfifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        rdreq;
  logic [31:0] rdata;
  logic        rvalid;
  logic [2:0]  usedw;
  logic        empty;
  logic        full;
  logic        almfull;
  logic        underflow;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  fim_wrack_scfifo #(
    .DATA_WIDTH(32),
    .DEPTH_LOG2(2),
    .ALMOST_FULL_THRESHOLD(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wdata(wdata),
    .wvalid(wvalid),
    .wready(wready),
    .rdreq(rdreq),
    .rdata(rdata),
    .rvalid(rvalid),
    .usedw(usedw),
    .empty(empty),
    .full(full),
    .almfull(almfull),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic [2:0]  usedw;
    logic        e;
    logic        f;
    logic        af;
    logic        wr;
    logic        rv;
    logic [31:0] rd;
    logic        uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic wv, logic [31:0] wd, logic rr,
                              logic [2:0] u, logic e, logic f, logic af, logic wr,
                              logic rv, logic [31:0] rd, logic uf);
    vec_t v;
    v.name = name; v.rst = rst; v.wv = wv; v.wd = wd; v.rr = rr;
    v.usedw = u; v.e = e; v.f = f; v.af = af; v.wr = wr; v.rv = rv; v.rd = rd; v.uf = uf;
    return v;
  endfunction

  // Drive inputs, take one edge, sample 1 ns later.
  task automatic step(input logic rst, input logic wv, input logic [31:0] wd, input logic rr);
    reset = rst; wvalid = wv; wdata = wd; rdreq = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [40:0] got, input logic [40:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got usedw/e/f/af/wr/rv/rdata/uf=%h req=%h", name, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wvalid = 1'b0; wdata = '0; rdreq = 1'b0;
    #2;

    //                 name        rst wv wd        rr  usedw e  f  af wr rv rdata     uf
    vecs.push_back(mk("reset",     1, 0, 32'h0,  0,  3'd0, 1, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk("fill_a0",   0, 1, 32'hA0, 0,  3'd1, 0, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk("fill_a1",   0, 1, 32'hA1, 0,  3'd2, 0, 0, 1, 1, 0, 32'h0,  0));
    vecs.push_back(mk("fill_a2",   0, 1, 32'hA2, 0,  3'd3, 0, 0, 1, 1, 0, 32'h0,  0));
    vecs.push_back(mk("fill_a3",   0, 1, 32'hA3, 0,  3'd4, 0, 1, 1, 0, 0, 32'h0,  0));
    vecs.push_back(mk("hold_a4",   0, 1, 32'hA4, 0,  3'd4, 0, 1, 1, 0, 0, 32'h0,  0));
    vecs.push_back(mk("drain_a0",  0, 1, 32'hA4, 1,  3'd3, 0, 0, 1, 1, 1, 32'hA0, 0));
    vecs.push_back(mk("drain_a1",  0, 1, 32'hA4, 1,  3'd3, 0, 0, 1, 1, 1, 32'hA1, 0));
    vecs.push_back(mk("drain_a2",  0, 0, 32'h0,  1,  3'd2, 0, 0, 1, 1, 1, 32'hA2, 0));
    vecs.push_back(mk("drain_a3",  0, 0, 32'h0,  1,  3'd1, 0, 0, 0, 1, 1, 32'hA3, 0));
    vecs.push_back(mk("drain_a4",  0, 0, 32'h0,  1,  3'd0, 1, 0, 0, 1, 1, 32'hA4, 0));
    vecs.push_back(mk("idle_hold", 0, 0, 32'h0,  0,  3'd0, 1, 0, 0, 1, 0, 32'hA4, 0));
    vecs.push_back(mk("fill_10",   0, 1, 32'h10, 0,  3'd1, 0, 0, 0, 1, 0, 32'hA4, 0));
    vecs.push_back(mk("fill_11",   0, 1, 32'h11, 0,  3'd2, 0, 0, 1, 1, 0, 32'hA4, 0));
    vecs.push_back(mk("fill_12",   0, 1, 32'h12, 0,  3'd3, 0, 0, 1, 1, 0, 32'hA4, 0));
    vecs.push_back(mk("fill_13",   0, 1, 32'h13, 0,  3'd4, 0, 1, 1, 0, 0, 32'hA4, 0));
    vecs.push_back(mk("full_pop",  0, 1, 32'hB0, 1,  3'd3, 0, 0, 1, 1, 1, 32'h10, 0));
    vecs.push_back(mk("late_b0",   0, 1, 32'hB0, 0,  3'd4, 0, 1, 1, 0, 0, 32'h10, 0));
    vecs.push_back(mk("pop_11",    0, 0, 32'h0,  1,  3'd3, 0, 0, 1, 1, 1, 32'h11, 0));
    vecs.push_back(mk("pop_12",    0, 0, 32'h0,  1,  3'd2, 0, 0, 1, 1, 1, 32'h12, 0));
    vecs.push_back(mk("pop_13",    0, 0, 32'h0,  1,  3'd1, 0, 0, 0, 1, 1, 32'h13, 0));
    vecs.push_back(mk("pop_b0",    0, 0, 32'h0,  1,  3'd0, 1, 0, 0, 1, 1, 32'hB0, 0));
    vecs.push_back(mk("empty_wr",  0, 1, 32'hC0, 1,  3'd1, 0, 0, 0, 1, 0, 32'hB0, 1));
    vecs.push_back(mk("pop_c0",    0, 0, 32'h0,  1,  3'd0, 1, 0, 0, 1, 1, 32'hC0, 1));
    vecs.push_back(mk("pre_e0",    0, 1, 32'hE0, 0,  3'd1, 0, 0, 0, 1, 0, 32'hC0, 1));
    vecs.push_back(mk("pre_e1",    0, 1, 32'hE1, 0,  3'd2, 0, 0, 1, 1, 0, 32'hC0, 1));
    vecs.push_back(mk("pre_e2",    0, 1, 32'hE2, 0,  3'd3, 0, 0, 1, 1, 0, 32'hC0, 1));
    vecs.push_back(mk("mid_reset", 1, 1, 32'hE3, 1,  3'd0, 1, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk("post_d0",   0, 1, 32'hD0, 0,  3'd1, 0, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk("pop_d0",    0, 0, 32'h0,  1,  3'd0, 1, 0, 0, 1, 1, 32'hD0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      check(vecs[i].name,
            {usedw, empty, full, almfull, wready, rvalid, rdata, underflow},
            {vecs[i].usedw, vecs[i].e, vecs[i].f, vecs[i].af, vecs[i].wr,
             vecs[i].rv, vecs[i].rd, vecs[i].uf});
    end

    // Wrap: stream 0..19 with wvalid and rdreq both held high.
    begin
      int unsigned sent = 0;
      int unsigned got  = 0;
      int unsigned cyc  = 0;
      logic        acc;
      logic        max_ok = 1'b1;
      step(1'b1, 1'b0, '0, 1'b0);
      while (got < 20 && cyc < 200) begin
        acc = (sent < 20) && wready;
        step(1'b0, sent < 20, sent, 1'b1);
        if (acc) sent++;
        if (usedw > 3'd2) max_ok = 1'b0;
        if (rvalid) begin
          n_checks++;
          if (rdata !== got) begin
            n_fails++;
            $display("FAIL wrap_data[%0d]: got %h req %h", got, rdata, got);
          end
          got++;
        end
        cyc++;
      end
      n_checks++;
      if (got != 20) begin
        n_fails++;
        $display("FAIL wrap_timeout: got %0d words req 20", got);
      end
      n_checks++;
      if (!max_ok) begin
        n_fails++;
        $display("FAIL wrap_usedw_max: usedw exceeded 2, req <= 2");
      end
      step(1'b0, 1'b0, '0, 1'b0);
      check("wrap_end", {usedw, empty, full, almfull, wready, rvalid, rdata, underflow},
            {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd19, 1'b1});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
